// File: rtl/ufm_arbiter.sv
// Two-port round-robin arbiter in front of an Avalon-MM UFM (port 0 = boot loader, port 1 = CSR host).
// Optional watchdog/err port enabled by defining UFM_ARB_TIMEOUT_EN.
module ufm_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] m0_addr,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic [15:0] m1_addr,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [15:0] ufm_addr,
    output logic [31:0] ufm_wdata,
    output logic        ufm_read,
    output logic        ufm_write,
    input  logic        ufm_waitrequest,
    input  logic [31:0] ufm_rdata,
    input  logic        ufm_rdvalid,
    output logic        busy
`ifdef UFM_ARB_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        gnt_q, gnt_d;
    logic        is_read_q, is_read_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ufm_read_q, ufm_read_d;
    logic        ufm_write_q, ufm_write_d;
    logic [31:0] rdata_q [2];
    logic        cap_en;
    logic [31:0] cap_data;
    logic        win;

    logic [1:0]  req;
    logic [1:0]  rd_req;
    logic [1:0]  ack_vec;
    logic [15:0] addr_in  [2];
    logic [31:0] wdata_in [2];

`ifdef UFM_ARB_TIMEOUT_EN
    logic [7:0]  wd_q, wd_d;
    logic        err_q, err_d;
`endif

    assign req      = {m1_read | m1_write, m0_read | m0_write};
    assign rd_req   = {m1_read, m0_read};
    assign addr_in  = '{m0_addr, m1_addr};
    assign wdata_in = '{m0_wdata, m1_wdata};

    // prio_q names the port that wins a tie; a lone requester always wins.
    assign win = (req == 2'b11) ? prio_q : req[1];

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ufm_read_d  = ufm_read_q;
        ufm_write_d = ufm_write_q;
        cap_en      = 1'b0;
        cap_data    = ufm_rdata;
`ifdef UFM_ARB_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d     = CMD;
                    gnt_d       = win;
                    prio_d      = ~win;
                    is_read_d   = rd_req[win];
                    addr_d      = addr_in[win];
                    wdata_d     = wdata_in[win];
                    ufm_read_d  = rd_req[win];
                    ufm_write_d = ~rd_req[win];
`ifdef UFM_ARB_TIMEOUT_EN
                    wd_d        = 8'd0;
`endif
                end
            end
            CMD: begin
                if (!ufm_waitrequest) begin
                    state_d     = is_read_q ? RDWAIT : ACK;
                    ufm_read_d  = 1'b0;
                    ufm_write_d = 1'b0;
                end
            end
            RDWAIT: begin
                if (ufm_rdvalid) begin
                    state_d = ACK;
                    cap_en  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UFM_ARB_TIMEOUT_EN
        // Watchdog overrides the normal CMD/RDWAIT exits once it saturates.
        if (state_q == CMD || state_q == RDWAIT) begin
            if (wd_q == 8'hFF) begin
                state_d     = ACK;
                ufm_read_d  = 1'b0;
                ufm_write_d = 1'b0;
                cap_en      = 1'b1;
                cap_data    = 32'hFFFF_FFFF;
                err_d       = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            is_read_q   <= 1'b0;
            addr_q      <= 16'd0;
            wdata_q     <= 32'd0;
            ufm_read_q  <= 1'b0;
            ufm_write_q <= 1'b0;
`ifdef UFM_ARB_TIMEOUT_EN
            wd_q        <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ufm_read_q  <= ufm_read_d;
            ufm_write_q <= ufm_write_d;
`ifdef UFM_ARB_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q[gi] <= 32'd0;
                end else if (cap_en && gnt_q == 1'(gi)) begin
                    rdata_q[gi] <= cap_data;
                end
            end
            assign ack_vec[gi] = (state_q == ACK) && (gnt_q == 1'(gi));
        end
    endgenerate

    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_ack    = ack_vec[0];
    assign m1_ack    = ack_vec[1];
    assign ufm_addr  = addr_q;
    assign ufm_wdata = wdata_q;
    assign ufm_read  = ufm_read_q;
    assign ufm_write = ufm_write_q;
    assign busy      = (state_q != IDLE);
`ifdef UFM_ARB_TIMEOUT_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_ufm_arbiter.sv
// Directed bench for ufm_arbiter; inputs driven on the falling edge, outputs sampled on the falling edge.
// The watchdog scenario is built only when UFM_ARB_TIMEOUT_EN is defined.
module tb_ufm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] m0_addr, m1_addr;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [15:0] ufm_addr;
    logic [31:0] ufm_wdata;
    logic        ufm_read, ufm_write;
    logic        ufm_waitrequest;
    logic [31:0] ufm_rdata;
    logic        ufm_rdvalid;
    logic        busy;
`ifdef UFM_ARB_TIMEOUT_EN
    logic        err;
`endif

    int vec_cnt = 0;
    int miscmp  = 0;

    always #5 clk = ~clk;

    ufm_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .m0_addr         (m0_addr),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_wdata        (m0_wdata),
        .m0_rdata        (m0_rdata),
        .m0_ack          (m0_ack),
        .m1_addr         (m1_addr),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_wdata        (m1_wdata),
        .m1_rdata        (m1_rdata),
        .m1_ack          (m1_ack),
        .ufm_addr        (ufm_addr),
        .ufm_wdata       (ufm_wdata),
        .ufm_read        (ufm_read),
        .ufm_write       (ufm_write),
        .ufm_waitrequest (ufm_waitrequest),
        .ufm_rdata       (ufm_rdata),
        .ufm_rdvalid     (ufm_rdvalid),
        .busy            (busy)
`ifdef UFM_ARB_TIMEOUT_EN
        ,
        .err             (err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_addr = '0; m0_read = 0; m0_write = 0; m0_wdata = '0;
        m1_addr = '0; m1_read = 0; m1_write = 0; m1_wdata = '0;
        ufm_waitrequest = 0; ufm_rdata = '0; ufm_rdvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec_cnt++; if ({ufm_read, ufm_write} !== 2'b00) begin miscmp++; $display("FAIL reset_cmd: got %b expected 00", {ufm_read, ufm_write}); end
        vec_cnt++; if ({m0_ack, m1_ack} !== 2'b00) begin miscmp++; $display("FAIL reset_ack: got %b expected 00", {m0_ack, m1_ack}); end
        vec_cnt++; if ({ufm_addr, ufm_wdata} !== 48'd0) begin miscmp++; $display("FAIL reset_addr_data: got %h expected 0", {ufm_addr, ufm_wdata}); end
        vec_cnt++; if ({m0_rdata, m1_rdata} !== 64'd0) begin miscmp++; $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata}); end
        $display("[%0t] reset: state cleared", $time);
    endtask

    task automatic test_single_read();
        m0_addr = 16'h0010; m0_read = 1;
        tick();  // CMD
        vec_cnt++; if ({ufm_read, ufm_write, ufm_addr} !== {2'b10, 16'h0010}) begin miscmp++; $display("FAIL rd_cmd: got %b%b %h expected 10 0010", ufm_read, ufm_write, ufm_addr); end
        vec_cnt++; if (busy !== 1'b1) begin miscmp++; $display("FAIL rd_busy: got %b expected 1", busy); end
        m0_addr = 16'h0055;  // must be ignored after the grant
        tick();  // RDWAIT
        vec_cnt++; if ({ufm_read, ufm_addr} !== {1'b0, 16'h0010}) begin miscmp++; $display("FAIL rd_rdwait: got %b %h expected 0 0010", ufm_read, ufm_addr); end
        vec_cnt++; if (m0_ack !== 1'b0) begin miscmp++; $display("FAIL rd_early_ack: got %b expected 0", m0_ack); end
        ufm_rdvalid = 1; ufm_rdata = 32'hDEADBEEF;
        tick();  // ACK, third edge after request
        vec_cnt++; if ({m0_ack, m1_ack} !== 2'b10) begin miscmp++; $display("FAIL rd_ack: got %b expected 10", {m0_ack, m1_ack}); end
        vec_cnt++; if (m0_rdata !== 32'hDEADBEEF) begin miscmp++; $display("FAIL rd_data: got %h expected deadbeef", m0_rdata); end
        vec_cnt++; if (m1_rdata !== 32'd0) begin miscmp++; $display("FAIL rd_other_rdata: got %h expected 0", m1_rdata); end
        ufm_rdvalid = 0; ufm_rdata = '0; m0_read = 0; m0_addr = '0;
        tick();
        vec_cnt++; if ({m0_ack, busy} !== 2'b00) begin miscmp++; $display("FAIL rd_done: got %b expected 00", {m0_ack, busy}); end
        $display("[%0t] single read m0 @0010 -> %h", $time, m0_rdata);
    endtask

    task automatic test_contention();
        do_reset();
        m0_addr = 16'h0100; m0_read = 1;
        m1_addr = 16'h0200; m1_read = 1;
        tick();
        vec_cnt++; if ({ufm_read, ufm_addr} !== {1'b1, 16'h0100}) begin miscmp++; $display("FAIL cont_first: got %b %h expected 1 0100", ufm_read, ufm_addr); end
        tick();
        ufm_rdvalid = 1; ufm_rdata = 32'hAAAA0000;
        tick();
        vec_cnt++; if ({m0_ack, m1_ack} !== 2'b10) begin miscmp++; $display("FAIL cont_ack0: got %b expected 10", {m0_ack, m1_ack}); end
        vec_cnt++; if (m0_rdata !== 32'hAAAA0000) begin miscmp++; $display("FAIL cont_data0: got %h expected aaaa0000", m0_rdata); end
        m0_read = 0; ufm_rdvalid = 0;
        tick();  // IDLE
        vec_cnt++; if ({busy, m0_ack, m1_ack} !== 3'b000) begin miscmp++; $display("FAIL cont_idle: got %b expected 000", {busy, m0_ack, m1_ack}); end
        tick();  // port 1 granted
        vec_cnt++; if ({ufm_read, ufm_addr} !== {1'b1, 16'h0200}) begin miscmp++; $display("FAIL cont_second: got %b %h expected 1 0200", ufm_read, ufm_addr); end
        tick();
        ufm_rdvalid = 1; ufm_rdata = 32'h00005555;
        tick();
        vec_cnt++; if ({m0_ack, m1_ack} !== 2'b01) begin miscmp++; $display("FAIL cont_ack1: got %b expected 01", {m0_ack, m1_ack}); end
        vec_cnt++; if ({m1_rdata, m0_rdata} !== {32'h00005555, 32'hAAAA0000}) begin miscmp++; $display("FAIL cont_data1: got %h %h expected 00005555 aaaa0000", m1_rdata, m0_rdata); end
        m1_read = 0; ufm_rdvalid = 0;
        tick();
        $display("[%0t] contention m0 @0100 then m1 @0200", $time);
    endtask

    task automatic test_wait_stall();
        m1_addr = 16'h0003; m1_wdata = 32'h12345678; m1_write = 1;
        ufm_waitrequest = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            vec_cnt++;
            if ({ufm_write, ufm_read, ufm_addr, ufm_wdata} !== {2'b10, 16'h0003, 32'h12345678} || m1_ack !== 1'b0) begin
                miscmp++;
                $display("FAIL stall_cycle%0d: got w%b r%b %h %h ack%b expected w1 r0 0003 12345678 ack0", i, ufm_write, ufm_read, ufm_addr, ufm_wdata, m1_ack);
            end
            if (i == 5) ufm_waitrequest = 0;
            tick();
        end
        vec_cnt++; if ({m1_ack, m0_ack, ufm_write} !== 3'b100) begin miscmp++; $display("FAIL stall_ack: got %b expected 100", {m1_ack, m0_ack, ufm_write}); end
        m1_write = 0;
        tick();
        $display("[%0t] stalled write m1 @0003 <- 12345678", $time);
    endtask

    task automatic test_rw_both();
        m0_addr = 16'h0020; m0_read = 1; m0_write = 1;
        tick();
        vec_cnt++; if ({ufm_read, ufm_write} !== 2'b10) begin miscmp++; $display("FAIL rw_cmd: got %b expected 10", {ufm_read, ufm_write}); end
        tick();
        vec_cnt++; if ({ufm_read, ufm_write, busy} !== 3'b001) begin miscmp++; $display("FAIL rw_rdwait: got %b expected 001", {ufm_read, ufm_write, busy}); end
        ufm_rdvalid = 1; ufm_rdata = 32'h0BADF00D;
        tick();
        vec_cnt++; if ({m0_ack, ufm_write, m0_rdata} !== {2'b10, 32'h0BADF00D}) begin miscmp++; $display("FAIL rw_ack: got %b%b %h expected 10 0badf00d", m0_ack, ufm_write, m0_rdata); end
        m0_read = 0; m0_write = 0; ufm_rdvalid = 0;
        tick();
        $display("[%0t] read+write m0 @0020 -> %h", $time, m0_rdata);
    endtask

    task automatic test_reset_rdwait();
        m1_addr = 16'h0044; m1_read = 1;
        tick();
        tick();
        vec_cnt++; if (busy !== 1'b1) begin miscmp++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
        rst = 1;
        tick();
        vec_cnt++; if ({busy, ufm_read, m1_ack, ufm_addr} !== 19'd0) begin miscmp++; $display("FAIL rst_mid_abort: got %b%b%b %h expected 000 0000", busy, ufm_read, m1_ack, ufm_addr); end
        rst = 0; m1_read = 0;
        ufm_rdvalid = 1; ufm_rdata = 32'h0000CAFE;
        tick();
        ufm_rdvalid = 0;
        tick();
        vec_cnt++; if ({busy, m0_ack, m1_ack, m1_rdata} !== 35'd0) begin miscmp++; $display("FAIL rst_mid_late_rdvalid: got %b%b%b %h expected 000 0", busy, m0_ack, m1_ack, m1_rdata); end
        $display("[%0t] reset during RDWAIT aborted m1 @0044", $time);
    endtask

    task automatic test_drop();
        do_reset();
        m0_addr = 16'h0005; m0_wdata = 32'h1; m0_write = 1;
        m1_addr = 16'h0006; m1_write = 1;
        tick();
        vec_cnt++; if ({ufm_write, ufm_addr} !== {1'b1, 16'h0005}) begin miscmp++; $display("FAIL drop_first: got %b %h expected 1 0005", ufm_write, ufm_addr); end
        m1_write = 0;
        tick();
        vec_cnt++; if (m0_ack !== 1'b1) begin miscmp++; $display("FAIL drop_ack0: got %b expected 1", m0_ack); end
        m0_write = 0;
        ufm_rdvalid = 1; ufm_rdata = 32'h99;
        tick();
        tick();
        ufm_rdvalid = 0;
        vec_cnt++; if ({busy, ufm_write, m1_ack, m0_rdata} !== 35'd0) begin miscmp++; $display("FAIL drop_no_access: got %b%b%b %h expected 000 0", busy, ufm_write, m1_ack, m0_rdata); end
        $display("[%0t] dropped m1 request discarded", $time);
    endtask

`ifdef UFM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit seen;
        do_reset();
        m0_addr = 16'h0007; m0_read = 1;
        n = 0; seen = 0;
        while (!seen && n < 400) begin
            tick();
            n++;
            if (m0_ack === 1'b1) seen = 1;
        end
        vec_cnt++; if (!seen || n < 250 || n > 260) begin miscmp++; $display("FAIL wd_ack_time: got seen=%b after %0d cycles expected ack in 250..260", seen, n); end
        vec_cnt++; if ({m0_rdata, err, ufm_read} !== {32'hFFFFFFFF, 2'b10}) begin miscmp++; $display("FAIL wd_result: got %h err%b rd%b expected ffffffff err1 rd0", m0_rdata, err, ufm_read); end
        m0_read = 0;
        tick();
        tick();
        vec_cnt++; if (err !== 1'b1) begin miscmp++; $display("FAIL wd_sticky: got %b expected 1", err); end
        do_reset();
        vec_cnt++; if (err !== 1'b0) begin miscmp++; $display("FAIL wd_clear: got %b expected 0", err); end
        $display("[%0t] watchdog on m0 @0007 after %0d cycles", $time, n);
    endtask
`endif

    initial begin
        rst = 1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_wait_stall();
        test_rw_both();
        test_reset_rdwait();
        test_drop();
`ifdef UFM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/ufm_arbiter.md
UFM_ARBITER -- requirements
Module: ufm_arbiter

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 mN_addr  input  16  word address from requester N (N = 0 boot config loader, N = 1 CSR host).
REQ-005 mN_read / mN_write  input  1 each  level request; held until mN_ack.
REQ-006 mN_wdata  input  32  write data from requester N.
REQ-007 mN_rdata  output  32  read data; valid only while mN_ack is high.
REQ-008 mN_ack  output  1  one-cycle completion pulse to requester N.
REQ-009 ufm_addr  output  16, ufm_wdata  output  32, ufm_read / ufm_write  output  1 each: Avalon-MM master to the UFM.
REQ-010 ufm_waitrequest  input  1, ufm_rdata  input  32, ufm_rdvalid  input  1: Avalon-MM responses from the UFM.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 err  output  1  sticky timeout flag; exists only with UFM_ARB_TIMEOUT_EN.

Function
REQ-013 The state machine SHALL have four states: IDLE, CMD, RDWAIT, ACK.
REQ-014 IDLE -> CMD on any pending request. The winner's address, data and direction are latched in that cycle. ufm_read or ufm_write is asserted from the next cycle.
REQ-015 Arbitration SHALL be round-robin on a last-grant bit; after reset the bit favours port 0.
REQ-016 With only one requester pending, that requester is granted with no idle penalty.
REQ-017 If mN_read and mN_write are both high, the request SHALL be treated as a read.
REQ-018 In CMD, the command, address and data SHALL be held stable while ufm_waitrequest is high.
REQ-019 CMD exit when ufm_waitrequest is low: to RDWAIT for a read, to ACK for a write.
REQ-020 RDWAIT -> ACK when ufm_rdvalid is high. ufm_rdata is captured into the granted mN_rdata in that cycle.
REQ-021 ACK asserts mN_ack for exactly one cycle, then returns to IDLE.
REQ-022 Minimum cycles from request to ack: read 4 (zero wait, rdvalid on the cycle after the command), write 3.
REQ-023 The ungranted port's ack SHALL stay low. Its rdata SHALL hold its last value.
REQ-024 Changes to the granted requester's inputs after the grant SHALL be ignored until its ack.
REQ-025 A request dropped before its grant SHALL be discarded without a UFM access.
REQ-026 ufm_rdvalid outside RDWAIT SHALL be ignored.
REQ-027 After an ack, the other port's pending request SHALL be granted in the following IDLE cycle.

Reset
REQ-028 Reset SHALL put the state machine in IDLE and set the last-grant bit to favour port 0.
REQ-029 Reset SHALL clear ufm_read, ufm_write, m0_ack, m1_ack, busy and err.
REQ-030 Reset SHALL zero ufm_addr, ufm_wdata, m0_rdata and m1_rdata.
REQ-031 Reset asserted mid-transaction SHALL abort the access. No ack SHALL be issued for the aborted access.

Configuration
REQ-032 Macro UFM_ARB_TIMEOUT_EN SHALL enable an 8-bit watchdog that counts cycles spent in CMD plus RDWAIT.
REQ-033 With UFM_ARB_TIMEOUT_EN, the watchdog reaching 255 SHALL force ACK with mN_rdata = 32'hFFFFFFFF and set err.
REQ-034 With UFM_ARB_TIMEOUT_EN, the forced ACK SHALL deassert ufm_read and ufm_write.
REQ-035 err SHALL clear only on reset.
REQ-036 Without UFM_ARB_TIMEOUT_EN, there SHALL be no watchdog and no err port; a transaction waits indefinitely.

Verification
REQ-037 Single read: m0_read, addr 0x0010; UFM zero-wait, rdvalid 1 cycle later with 0xDEADBEEF -> m0_ack 4 cycles after the request, m0_rdata = 0xDEADBEEF.
REQ-038 Contention: m0_read and m1_read asserted in the same cycle after reset -> port 0 acked first, port 1 granted in the next IDLE cycle, ufm_addr shows m0 then m1 address.
REQ-039 Waitrequest stall: m1_write, addr 0x0003, data 0x12345678, waitrequest high for 5 cycles -> ufm_write, address and data stable for 6 cycles, m1_ack one cycle after waitrequest falls.
REQ-040 Read/write both high on m0 -> ufm_read asserted, ufm_write never asserted.
REQ-041 Reset asserted during RDWAIT -> next cycle IDLE, busy 0, no ack; a later rdvalid is ignored.
REQ-042 With UFM_ARB_TIMEOUT_EN, m0_read and rdvalid never asserted -> m0_ack with 0xFFFFFFFF after 255 cycles, err = 1 until reset.
